fwft_gather_reader: RTL and testbench

// - Converts a standard read-latency-1 FIFO port (rd_en -> valid/data next enabled cycle) into a

---
 rtl/fwft_gather_reader_pkg.sv | 9 +
 rtl/fwft_gather_reader.sv | 78 +++++++
 tb/tb_fwft_gather_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwft_gather_reader_pkg.sv
// Shared constants for the FWFT gather reader: buffer depth and derived pointer/count widths.
package fwft_gather_reader_pkg;

    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned SUM_W     = CNT_W + 1;

endpackage

// File: rtl/fwft_gather_reader.sv
// Turns a read-latency-1 FIFO port into a first-word-fall-through port,
// optionally gathering `words` consecutive FIFO words into one wide output word.
module fwft_gather_reader
    import fwft_gather_reader_pkg::*;
#(
    parameter int unsigned dta_width = 64,
    parameter int unsigned words     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    output logic                         fifo_rd_en,
    input  logic                         fifo_valid,
    input  logic [dta_width-1:0]         fifo_dout,
    output logic                         valid,
    output logic [words*dta_width-1:0]   dout,
    input  logic                         rd_en
);

    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(words);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [dta_width-1:0] buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     count_after_pop;
    logic                 inflight_q, inflight_d;
    logic                 push;
    logic                 pop;

    // Credit check covers both buffered words and the one possibly still in flight.
    assign fifo_rd_en = clk_en & ~rst &
                        ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(BUF_DEPTH));

    assign valid = (count_q >= WORDS_C);

    always_comb begin
        pop             = clk_en & rd_en & valid;
        count_after_pop = pop ? (count_q - WORDS_C) : count_q;
        push            = clk_en & fifo_valid & (count_after_pop < DEPTH_C);
        count_d         = count_after_pop + CNT_W'(push);
        rd_ptr_d        = pop  ? (rd_ptr_q + PTR_W'(words)) : rd_ptr_q;
        wr_ptr_d        = push ? (wr_ptr_q + PTR_W'(1))     : wr_ptr_q;
        inflight_d      = clk_en ? fifo_rd_en : inflight_q;
    end

    // Oldest word goes to the MSBs; slots not yet filled read as zero.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < words; i++) begin
            if (count_q > CNT_W'(i)) begin
                dout[(words-1-i)*dta_width +: dta_width] = buf_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (push) begin
                buf_q[wr_ptr_q] <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_fwft_gather_reader.sv
// Randomized self-checking bench for fwft_gather_reader with a queue-based reference model,
// exercising a words=1/3-bit instance and a words=2/64-bit instance.
module tb_fwft_gather_reader;

    logic clk = 1'b0;
    logic rst;

    logic         ce0, fv0, re0, frd0, v0;
    logic [2:0]   fd0, do0;
    logic         ce1, fv1, re1, frd1, v1;
    logic [63:0]  fd1;
    logic [127:0] do1;

    int errors = 0;
    int checks = 0;

    logic [63:0]  mq0[$], mq1[$], src0[$], src1[$];
    logic [127:0] got[$];
    bit           infl[2];
    bit           pend[2];

    always #5 clk = ~clk;

    fwft_gather_reader #(.dta_width(3), .words(1)) u0 (
        .clk(clk), .rst(rst), .clk_en(ce0), .fifo_rd_en(frd0), .fifo_valid(fv0),
        .fifo_dout(fd0), .valid(v0), .dout(do0), .rd_en(re0)
    );

    fwft_gather_reader #(.dta_width(64), .words(2)) u1 (
        .clk(clk), .rst(rst), .clk_en(ce1), .fifo_rd_en(frd1), .fifo_valid(fv1),
        .fifo_dout(fd1), .valid(v1), .dout(do1), .rd_en(re1)
    );

    task automatic model_reset();
        mq0.delete(); mq1.delete(); src0.delete(); src1.delete(); got.delete();
        infl[0] = 0; infl[1] = 0; pend[0] = 0; pend[1] = 0;
    endtask

    // One enabled-or-not clock of instance k; the other instance is held idle.
    task automatic tick(input int k, input bit ce, input bit allow, input bit re);
        logic [63:0]  q[$];
        logic [63:0]  s[$];
        logic [127:0] exp_do, act_do;
        logic [63:0]  wd, tmp;
        logic         act_frd, act_v, exp_frd, exp_v, push, pop;
        int           w, act_cnt;
        if (k == 0) begin q = mq0; s = src0; w = 1; end
        else        begin q = mq1; s = src1; w = 2; end
        push = ce && pend[k] && allow && (s.size() > 0);
        wd = {$urandom, $urandom};
        if (push) wd = s.pop_front();
        if (k == 0) begin
            ce0 = ce; re0 = re; fv0 = ce ? push : 1'($urandom); fd0 = wd[2:0];
            ce1 = 1'b0; re1 = 1'b0; fv1 = 1'b0;
        end else begin
            ce1 = ce; re1 = re; fv1 = ce ? push : 1'($urandom); fd1 = wd;
            ce0 = 1'b0; re0 = 1'b0; fv0 = 1'b0;
        end
        #1;
        if (k == 0) begin
            act_frd = frd0; act_v = v0; act_do = 128'(do0); act_cnt = int'(u0.count_q);
        end else begin
            act_frd = frd1; act_v = v1; act_do = do1; act_cnt = int'(u1.count_q);
        end
        exp_frd = ce && ((q.size() + int'(infl[k])) < 4);
        exp_v   = (q.size() >= w);
        exp_do  = '0;
        if (k == 0) begin
            if (q.size() > 0) exp_do = 128'(q[0]);
        end else begin
            if (q.size() > 0) exp_do[127:64] = q[0];
            if (q.size() > 1) exp_do[63:0]   = q[1];
        end
        checks++;
        if (act_frd !== exp_frd) begin
            errors++;
            $display("FAIL fifo_rd_en k=%0d t=%0t got %b exp %b", k, $time, act_frd, exp_frd);
        end
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL valid k=%0d t=%0t got %b exp %b", k, $time, act_v, exp_v);
        end
        checks++;
        if (act_do !== exp_do) begin
            errors++;
            $display("FAIL dout k=%0d t=%0t got %h exp %h", k, $time, act_do, exp_do);
        end
        checks++;
        if (act_cnt !== q.size() || act_cnt > 4) begin
            errors++;
            $display("FAIL count k=%0d t=%0t got %0d exp %0d", k, $time, act_cnt, q.size());
        end
        @(posedge clk); #1;
        if (ce) begin
            pop = re && exp_v;
            if (pop) begin
                got.push_back(act_do);
                for (int i = 0; i < w; i++) tmp = q.pop_front();
            end
            if (push) q.push_back(wd);
            infl[k] = exp_frd;
            pend[k] = exp_frd;
        end
        if (k == 0) begin mq0 = q; src0 = s; end
        else        begin mq1 = q; src1 = s; end
    endtask

    task automatic check_got(input string name, input logic [63:0] exp[$]);
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL %s popped count got %0d exp %0d", name, got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== 128'(exp[i])) begin
                    errors++;
                    $display("FAIL %s word %0d got %h exp %h", name, i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce0 = 1'b1; ce1 = 1'b1; re0 = 0; re1 = 0; fv0 = 0; fv1 = 0; fd0 = 0; fd1 = 0;
        #1;
        checks++;
        if (frd0 !== 1'b0 || v0 !== 1'b0 || do0 !== 3'd0 || v1 !== 1'b0 || do1 !== 128'd0) begin
            errors++;
            $display("FAIL reset_state got frd=%b v0=%b do0=%h v1=%b do1=%h exp all zero",
                     frd0, v0, do0, v1, do1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) tick(0, 1'b1, 1'b0, 1'b0);
        src0 = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        for (int i = 0; i < 4; i++) tick(0, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (v0 !== 1'b0 || do0 !== 3'd0 || frd0 !== 1'b0 || u0.count_q !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b dout=%h frd=%b cnt=%0d exp 0 0 0 0",
                     v0, do0, frd0, u0.count_q);
        end
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        model_reset();
        src0 = '{64'd5, 64'd2, 64'd7};
        tick(0, 1'b1, 1'b1, 1'b1);
        tick(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (v0 !== 1'b1 || do0 !== 3'd5) begin
            errors++;
            $display("FAIL latency1 got v=%b dout=%0d exp v=1 dout=5", v0, do0);
        end
        for (int i = 0; i < 6; i++) tick(0, 1'b1, 1'b1, 1'b1);
        check_got("stream", '{64'd5, 64'd2, 64'd7});
    endtask

    task automatic test_gather();
        logic [63:0] a, b;
        a = 64'h1111111111111111;
        b = 64'h2222222222222222;
        model_reset();
        src1 = '{a, b};
        tick(1, 1'b1, 1'b1, 1'b0);
        tick(1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (v1 !== 1'b0) begin
            errors++;
            $display("FAIL gather_early got v=%b exp 0", v1);
        end
        tick(1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (v1 !== 1'b1 || do1 !== {a, b}) begin
            errors++;
            $display("FAIL gather_word got v=%b dout=%h exp v=1 dout=%h", v1, do1, {a, b});
        end
        tick(1, 1'b1, 1'b1, 1'b1);
        tick(1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (v1 !== 1'b0) begin
            errors++;
            $display("FAIL gather_drop got v=%b exp 0", v1);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] words_in[$];
        model_reset();
        for (int i = 0; i < 6; i++) words_in.push_back(64'($urandom_range(0, 7)));
        src0 = words_in;
        for (int i = 0; i < 8; i++) tick(0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (frd0 !== 1'b0 || u0.count_q !== 3'd4) begin
            errors++;
            $display("FAIL backpressure got frd=%b cnt=%0d exp frd=0 cnt=4", frd0, u0.count_q);
        end
        for (int i = 0; i < 12; i++) tick(0, 1'b1, 1'b1, 1'b1);
        check_got("backpressure", words_in);
    endtask

    task automatic test_clk_en();
        model_reset();
        src0 = '{64'd5, 64'd2, 64'd7};
        for (int i = 0; i < 16; i++) tick(0, (i % 2) == 0, 1'b1, 1'b1);
        check_got("clk_en", '{64'd5, 64'd2, 64'd7});
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            model_reset();
            for (int i = 0; i < 5000; i++) begin
                while ((k == 0 ? src0.size() : src1.size()) < 4) begin
                    if (k == 0) src0.push_back(64'($urandom_range(0, 7)));
                    else        src1.push_back({$urandom, $urandom});
                end
                tick(k, ($urandom % 8) != 0, ($urandom % 4) != 0, 1'($urandom));
            end
            checks++;
            if (got.size() < 100) begin
                errors++;
                $display("FAIL random_progress k=%0d got %0d pops exp at least 100", k, got.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gather();
        test_backpressure();
        test_clk_en();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
